// File: rtl/ram_ctrl.sv
// Single-port RAM sequencer: one request at a time, write or read with a
// turnaround cycle on the shared bidirectional data bus after every access.
//
//   state | meaning
//   IDLE  | ready for a request, bus released, strobes low
//   WRITE | ram_we high, registered write data driven onto ram_data
//   READ  | ram_enable high for RD_LAT cycles, data captured on the last edge
//   TURN  | bus turnaround; rsp_valid pulses here when the access was a read
module ram_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_we,
    output logic              ram_enable,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

    localparam int                CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                drive_bus;
    logic                accept;
    logic                rd_done;

    assign accept  = req_valid && req_ready;
    assign rd_done = (state_q == READ) && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        ram_we     = 1'b0;
        ram_enable = 1'b0;
        rsp_valid  = 1'b0;
        drive_bus  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_we ? WRITE : READ;
            end
            WRITE: begin
                ram_we    = 1'b1;
                drive_bus = 1'b1;
                state_d   = TURN;
            end
            READ: begin
                ram_enable = 1'b1;
                if (cnt_q == '0) state_d = TURN;
            end
            TURN: begin
                // we_q tells which access this turnaround follows
                rsp_valid = ~we_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == READ && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (rd_done) rdata_q <= ram_data;
        end
    end

    assign ram_addr  = addr_q;
    assign rsp_rdata = rdata_q;
    assign ram_data  = drive_bus ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning RAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1 (legal 1..4), meaning the number of cycles ram_enable is held before read data is sampled.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: controller can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: target address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle pulse, read data valid.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_W bits: last read data.
REQ-013 The block SHALL have port ram_we, output, 1 bit: RAM write strobe.
REQ-014 The block SHALL have port ram_enable, output, 1 bit: RAM read enable.
REQ-015 The block SHALL have port ram_addr, output, ADDR_W bits: RAM address.
REQ-016 The block SHALL have port ram_data, inout, DATA_W bits: shared RAM data bus.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, WRITE, READ and TURN.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid && req_ready.
REQ-019 On accept, the block SHALL register req_addr, req_we and req_wdata; the registered values SHALL stay stable until the next accept regardless of request-side inputs.
REQ-020 An accepted write SHALL go IDLE -> WRITE (1 cycle) -> TURN (1 cycle) -> IDLE.
REQ-021 In WRITE, the block SHALL drive ram_we=1, ram_enable=0, ram_addr=registered address and ram_data=registered wdata.
REQ-022 An accepted read SHALL go IDLE -> READ (RD_LAT cycles, tracked by a down-counter) -> TURN -> IDLE.
REQ-023 In READ, the block SHALL drive ram_enable=1, ram_we=0 and ram_addr=registered address, with ram_data released (high-Z).
REQ-024 On the clock edge that ends the last READ cycle, the block SHALL capture ram_data into rsp_rdata.
REQ-025 rsp_valid SHALL be 1 for exactly the TURN cycle that follows a READ, and 0 at all other times.
REQ-026 rsp_rdata SHALL hold its value until the next read capture.
REQ-027 In TURN and IDLE, the block SHALL hold ram_we=0 and ram_enable=0, with ram_data high-Z (bus turnaround; no contention).
REQ-028 The block SHALL drive ram_data only in WRITE; at all other times ram_data SHALL be high-Z.
REQ-029 ram_we and ram_enable SHALL never both be 1.
REQ-030 ram_addr SHALL hold the last registered address outside active states.
REQ-031 Throughput: a write SHALL take 3 cycles from accept to the next req_ready, and a read SHALL take RD_LAT+2 cycles.
REQ-032 Back-to-back requests held on req_valid SHALL be accepted in the first IDLE cycle after TURN.
REQ-033 The block SHALL accept no request while not in IDLE, even if req_valid=1.

Reset
REQ-034 While rst=1 at a clock edge, the block SHALL go to state IDLE next cycle.
REQ-035 After reset, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, ram_we=0, ram_enable=0, ram_addr=0, ram_data high-Z.
REQ-036 The READ counter and registered request fields SHALL clear to 0 on reset.
REQ-037 Reset asserted in WRITE, READ or TURN SHALL abort the transaction with no rsp_valid pulse, and the aborted read SHALL not update rsp_rdata.
REQ-038 rst SHALL take priority over a simultaneous req_valid.

Verification
REQ-039 The bench SHALL cover: reset, then write addr 4'h3 data 8'hA5 -> ram_we=1 for exactly 1 cycle with ram_addr=3 and ram_data=A5, then req_ready=1 3 cycles after accept.
REQ-040 The bench SHALL cover: write 16 addresses with data=addr, then read all 16 (RD_LAT=1) -> each rsp_rdata equals addr, 16 rsp_valid pulses, each read taking 3 cycles.
REQ-041 The bench SHALL cover: read with RD_LAT=3 at addr 4'hF after writing 8'h5C -> ram_enable high for 3 cycles, then rsp_valid with rsp_rdata=5C.
REQ-042 The bench SHALL cover: req_valid held high across write-then-read -> the second request is accepted in the first IDLE cycle after TURN, with no overlap of ram_we/ram_enable and ram_data never X (no contention).
REQ-043 The bench SHALL cover: rst pulsed during the READ of addr 2 -> no rsp_valid, rsp_rdata=0, all RAM strobes 0 on the next cycle.
REQ-044 The bench SHALL cover: req_valid and rst high on the same edge -> no accept, state IDLE.
